// File: rtl/aes_round_engine.sv
// Iterative AES encryption core: one full cipher round per clock, 10/12/14 rounds
// selected by NR, driven from an externally held, precomputed key schedule.
module aes_round_engine #(
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [127:0]            in_data,
  input  logic [128*(NR+1)-1:0]   key_sched,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            out_data,
  output logic                    busy,
  output logic [3:0]              round_idx
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_engine: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  fsm_t         fsm_reg, fsm_next;
  logic [127:0] state_reg, state_next;
  logic [3:0]   round_reg, round_next;

  logic [127:0] rk [NR+1];
  logic [127:0] sr_w, mc_w, load_w, round_w, final_w;

  for (genvar gi = 0; gi <= NR; gi++) begin : g_rk
    assign rk[gi] = key_sched[128*gi +: 128];
  end

  // SubBytes fused with ShiftRows: output s[r][c] takes input s[r][(c+r)%4].
  for (genvar gi = 0; gi < 16; gi++) begin : g_sr
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
    assign sr_w[127-8*gi -: 8] = sbox(state_reg[127-8*SRC -: 8]);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mc
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr_w[127-32*gi -: 8];
    assign a1 = sr_w[119-32*gi -: 8];
    assign a2 = sr_w[111-32*gi -: 8];
    assign a3 = sr_w[103-32*gi -: 8];
    assign mc_w[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc_w[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc_w[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc_w[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  assign load_w  = in_data ^ rk[0];
  assign round_w = mc_w ^ rk[round_reg];
  assign final_w = sr_w ^ rk[round_reg];

  always_comb begin
    fsm_next   = fsm_reg;
    state_next = state_reg;
    round_next = round_reg;
    in_ready   = (fsm_reg == IDLE) || (fsm_reg == DONE && out_ready);
    case (fsm_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = load_w;
          round_next = 4'd1;
          fsm_next   = RUN;
        end
      end
      RUN: begin
        if (round_reg == NR_L) begin
          state_next = final_w;
          fsm_next   = DONE;
        end else begin
          state_next = round_w;
          round_next = round_reg + 4'd1;
        end
      end
      DONE: begin
        // A new block may be taken on the same edge as the output handshake.
        if (out_ready) begin
          if (in_valid) begin
            state_next = load_w;
            round_next = 4'd1;
            fsm_next   = RUN;
          end else begin
            round_next = 4'd0;
            fsm_next   = IDLE;
          end
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg   <= IDLE;
      state_reg <= '0;
      round_reg <= '0;
    end else begin
      fsm_reg   <= fsm_next;
      state_reg <= state_next;
      round_reg <= round_next;
    end
  end

  assign out_valid = (fsm_reg == DONE);
  assign busy      = (fsm_reg != IDLE);
  assign out_data  = state_reg;
  assign round_idx = round_reg;

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: three instances (NR=10/12/14) checked against a
// byte-array AES model with its own key expansion and a GF(2^8)-derived S-box.
module tb_aes_round_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]        iv, ordy, ir, ov, bz;
  logic [2:0][127:0] id, od;
  logic [2:0][3:0]   ri;
  logic [1407:0]     ks10;
  logic [1663:0]     ks12;
  logic [1919:0]     ks14;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb_t [256];

  aes_round_engine #(.NR(10)) u_dut10 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .key_sched(ks10), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .busy(bz[0]), .round_idx(ri[0]));

  aes_round_engine #(.NR(12)) u_dut12 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .key_sched(ks12), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .busy(bz[1]), .round_idx(ri[1]));

  aes_round_engine #(.NR(14)) u_dut14 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .key_sched(ks14), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
    .busy(bz[2]), .round_idx(ri[2]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_t[w[31:24]], sb_t[w[23:16]], sb_t[w[15:8]], sb_t[w[7:0]]};
  endfunction

  // Key is left-aligned in 256 bits; nk = 4, 6 or 8 words.
  function automatic logic [1919:0] key_expand(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   tmp;
    logic [7:0]    rc = 8'h01;
    logic [1919:0] s = '0;
    int            nw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < nw / 4; r++)
      s[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [1919:0] sched,
                                               input int nr);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] rk, res;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = pt[127-8*(r+4*c) -: 8];
    for (int rnd = 0; rnd <= nr; rnd++) begin
      if (rnd > 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) t[r][c] = sb_t[s[r][(c+r)%4]];
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            s[r][c] = (rnd == nr) ? t[r][c] :
                      gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
      end
      rk = sched[128*rnd +: 128];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ rk[127-8*(r+4*c) -: 8];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[127-8*(r+4*c) -: 8] = s[r][c];
    return res;
  endfunction

  task automatic set_ks(input int i, input logic [1919:0] s);
    case (i)
      0:       ks10 = s[1407:0];
      1:       ks12 = s[1663:0];
      default: ks14 = s;
    endcase
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] rand_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    iv = 3'b111;               // reset must win over an offered block
    ordy = 3'b111;
    id[0] = rand_blk(); id[1] = rand_blk(); id[2] = rand_blk();
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || bz[i] !== 1'b0 || ri[i] !== 4'd0 || od[i] !== 128'h0) begin
        errors++;
        $display("FAIL reset_state inst%0d: ov=%b busy=%b ri=%0d od=%h, required 0/0/0/0", i, ov[i], bz[i], ri[i], od[i]);
      end
    end
    iv = 3'b000;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ir[i] !== 1'b1 || bz[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_release inst%0d: in_ready=%b busy=%b, required 1/0", i, ir[i], bz[i]);
      end
    end
    $display("reset: all instances idle");
  endtask

  // One block through instance i; exp_ct used when use_exp, else the model.
  task automatic test_block(input int i, input logic [255:0] key, input logic [127:0] pt,
                            input logic [127:0] exp_ct, input bit use_exp, input string name);
    int            nr = 10 + 2 * i;
    int            e;
    logic [1919:0] sched;
    logic [127:0]  expv;
    sched = key_expand(key, nr - 6);
    expv  = use_exp ? exp_ct : ref_encrypt(pt, sched, nr);
    @(negedge clk);
    set_ks(i, sched);
    id[i] = pt; iv[i] = 1'b1; ordy[i] = 1'b1;
    checks++;
    if (ir[i] !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready: got %b required 1", name, ir[i]);
    end
    @(negedge clk);
    iv[i] = 1'b0;
    e = 0;
    while (ov[i] !== 1'b1 && e < 40) begin
      checks++;
      if (ri[i] !== 4'(e + 1)) begin
        errors++;
        $display("FAIL %s round_idx: got %0d required %0d", name, ri[i], e + 1);
      end
      @(negedge clk);
      e++;
    end
    checks++;
    if (e != nr) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, e, nr);
    end
    checks++;
    if (od[i] !== expv || ri[i] !== 4'(nr)) begin
      errors++;
      $display("FAIL %s ciphertext: got %h ri=%0d required %h ri=%0d", name, od[i], ri[i], expv, nr);
    end
    $display("block %s nr=%0d pt=%h ct=%h", name, nr, pt, od[i]);
    @(negedge clk);
    checks++;
    if (ov[i] !== 1'b0 || bz[i] !== 1'b0 || ri[i] !== 4'd0) begin
      errors++;
      $display("FAIL %s return_idle: ov=%b busy=%b ri=%0d required 0/0/0", name, ov[i], bz[i], ri[i]);
    end
  endtask

  task automatic test_kat();
    test_block(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 128'h00112233445566778899aabbccddeeff,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, "kat128_a");
    test_block(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 128'h3243f6a8885a308d313198a2e0370734,
               128'h3925841d02dc09fbdc118597196a0b32, 1'b1, "kat128_b");
    test_block(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
               128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 1'b1, "kat192");
    test_block(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 1'b1, "kat256");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 2; k++)
        test_block(i, rand_key(), rand_blk(), 128'h0, 1'b0, $sformatf("rand_i%0d_%0d", i, k));
  endtask

  task automatic test_backpressure();
    logic [1919:0] sched;
    logic [127:0]  pt_a, pt_b, exp_a, exp_b;
    int            e;
    sched = key_expand(rand_key(), 4);
    pt_a = rand_blk(); pt_b = rand_blk();
    exp_a = ref_encrypt(pt_a, sched, 10);
    exp_b = ref_encrypt(pt_b, sched, 10);
    @(negedge clk);
    set_ks(0, sched);
    id[0] = pt_a; iv[0] = 1'b1; ordy[0] = 1'b0;
    @(negedge clk);
    iv[0] = 1'b0;
    e = 0;
    while (ov[0] !== 1'b1 && e < 40) begin @(negedge clk); e++; end
    checks++;
    if (e != 10) begin
      errors++;
      $display("FAIL bp_first_latency: got %0d required 10", e);
    end
    id[0] = pt_b; iv[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (ov[0] !== 1'b1 || od[0] !== exp_a || ir[0] !== 1'b0 || bz[0] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: ov=%b od=%h in_ready=%b required 1 %h 0", k, ov[0], od[0], ir[0], exp_a);
      end
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    #1;
    checks++;
    if (ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release in_ready: got %b required 1", ir[0]);
    end
    @(negedge clk);
    iv[0] = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || ri[0] !== 4'd1 || bz[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_same_edge_accept: ov=%b ri=%0d busy=%b required 0/1/1", ov[0], ri[0], bz[0]);
    end
    e = 0;
    while (ov[0] !== 1'b1 && e < 40) begin @(negedge clk); e++; end
    checks++;
    if (e != 10 || od[0] !== exp_b) begin
      errors++;
      $display("FAIL bp_second_block: latency %0d ct %h required 10 %h", e, od[0], exp_b);
    end
    $display("backpressure: held 20 cycles, second ct=%h", od[0]);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1919:0] sched;
    logic [127:0]  blk [4];
    logic [127:0]  expv [4];
    int            acc_t [4];
    int            nacc, nout, cyc;
    sched = key_expand(rand_key(), 4);
    for (int k = 0; k < 4; k++) begin
      blk[k] = rand_blk();
      expv[k] = ref_encrypt(blk[k], sched, 10);
    end
    @(negedge clk);
    set_ks(0, sched);
    ordy[0] = 1'b1; id[0] = blk[0]; iv[0] = 1'b1;
    cyc = 0; nout = 0; nacc = 0;
    if (ir[0] === 1'b1) begin acc_t[0] = 0; nacc = 1; end
    while (nout < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ov[0] === 1'b1) begin
        checks++;
        if (od[0] !== expv[nout]) begin
          errors++;
          $display("FAIL stream_ct%0d: got %h required %h", nout, od[0], expv[nout]);
        end
        $display("stream out %0d at cycle %0d ct=%h", nout, cyc, od[0]);
        nout++;
      end
      if (nacc < 4) begin
        id[0] = blk[nacc]; iv[0] = 1'b1;
        if (ir[0] === 1'b1) begin acc_t[nacc] = cyc; nacc++; end
      end else begin
        iv[0] = 1'b0;
      end
    end
    iv[0] = 1'b0;
    checks++;
    if (nout != 4 || nacc != 4) begin
      errors++;
      $display("FAIL stream_count: outputs %0d accepts %0d required 4 4", nout, nacc);
    end
    for (int k = 1; k < nacc; k++) begin
      checks++;
      if (acc_t[k] - acc_t[k-1] != 11) begin
        errors++;
        $display("FAIL stream_spacing%0d: got %0d required 11", k, acc_t[k] - acc_t[k-1]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int e, stale;
    @(negedge clk);
    set_ks(0, key_expand(rand_key(), 4));
    id[0] = rand_blk(); iv[0] = 1'b1; ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    e = 0;
    while (ri[0] !== 4'd5 && e < 40) begin @(negedge clk); e++; end
    checks++;
    if (ri[0] !== 4'd5) begin
      errors++;
      $display("FAIL midrun_reach_round5: got %0d required 5", ri[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || ri[0] !== 4'd0 || ir[0] !== 1'b1 || od[0] !== 128'h0) begin
      errors++;
      $display("FAIL midrun_reset: ov=%b busy=%b ri=%0d in_ready=%b od=%h required 0/0/0/1/0",
               ov[0], bz[0], ri[0], ir[0], od[0]);
    end
    stale = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ov[0] !== 1'b0 || bz[0] !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL midrun_stale_output: %0d cycles with activity, required 0", stale);
    end
    $display("reset at round 5: engine cleared");
    test_block(0, rand_key(), rand_blk(), 128'h0, 1'b0, "after_reset");
  endtask

  initial begin
    iv = '0; ordy = '1; id = '0;
    ks10 = '0; ks12 = '0; ks14 = '0;
    build_sbox();
    test_reset();
    test_kat();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
